// File: rtl/mmio_store_sink.sv
// Store-side MMIO responder: buffers in-window stores in a FIFO, tracks tohost pass/fail and counts stores.
// Optional alignment checking is enabled by defining MMIO_ALIGN_CHECK_EN.
module mmio_store_sink #(
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0100,
    parameter logic [31:0] MMIO_SIZE   = 32'h0000_0040,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0064,
    parameter logic [31:0] PASS_VALUE  = 32'd25,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   data,
    input  logic                          we,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_addr,
    output logic [31:0]                   out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          misalign,
    output logic                          pass,
    output logic                          fail,
    output logic [CNT_W-1:0]              store_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    logic [31:0]      memAddr [FIFO_DEPTH];
    logic [31:0]      memData [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [LVL_W-1:0] level;
    logic [1:0]       state;
    logic             overflowReg;
    logic [CNT_W-1:0] countReg;

    logic        running;
    logic        storeActive;
    logic [32:0] addrExt;
    logic [32:0] offsetExt;
    logic        inWindow;
    logic        isTohost;
    logic        hit;
    logic        misaligned;
    logic        full;
    logic        popEn;
    logic        pushReq;
    logic        pushEn;
    logic        dropped;

    // Window decode is done in 33 bits so base+size can never wrap around.
    always_comb begin
        running     = (state == ST_RUN);
        storeActive = we & running;
        addrExt     = {1'b0, addr};
        offsetExt   = addrExt - {1'b0, MMIO_BASE};
        inWindow    = (addrExt >= {1'b0, MMIO_BASE}) && (offsetExt < {1'b0, MMIO_SIZE});
        isTohost    = (addr == TOHOST_ADDR);
        hit         = storeActive & inWindow & ~isTohost;
`ifdef MMIO_ALIGN_CHECK_EN
        misaligned  = (addr[1:0] != 2'b00);
`else
        misaligned  = 1'b0;
`endif
        full        = (level == LVL_W'(FIFO_DEPTH));
        popEn       = (level != '0) & out_ready;
        pushReq     = hit & ~misaligned;
        pushEn      = pushReq & (~full | popEn);
        dropped     = pushReq & full & ~popEn;
    end

    // FIFO storage and pointers; a pop frees the slot a same-cycle push into a full FIFO needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                memAddr[i] <= '0;
                memData[i] <= '0;
            end
        end else begin
            if (pushEn) begin
                memAddr[wrPtr] <= offsetExt[31:0];
                memData[wrPtr] <= data;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (pushEn && !popEn) begin
                level <= level + 1'b1;
            end else if (!pushEn && popEn) begin
                level <= level - 1'b1;
            end
        end
    end

    // Status FSM: the first aligned tohost store decides pass or fail; both are terminal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (storeActive && isTohost && !misaligned) begin
            state <= (data == PASS_VALUE) ? ST_PASS : ST_FAIL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg    <= '0;
            overflowReg <= 1'b0;
        end else begin
            if (storeActive && (countReg != '1)) begin
                countReg <= countReg + 1'b1;
            end
            if (dropped) begin
                overflowReg <= 1'b1;
            end
        end
    end

`ifdef MMIO_ALIGN_CHECK_EN
    logic misalignReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalignReg <= 1'b0;
        end else if (storeActive && misaligned && (inWindow || isTohost)) begin
            misalignReg <= 1'b1;
        end
    end

    assign misalign = misalignReg;
`else
    assign misalign = 1'b0;
`endif

    assign out_valid   = (level != '0);
    assign out_addr    = memAddr[rdPtr];
    assign out_data    = memData[rdPtr];
    assign fifo_level  = level;
    assign overflow    = overflowReg;
    assign pass        = (state == ST_PASS);
    assign fail        = (state == ST_FAIL);
    assign store_count = countReg;

endmodule

// File: tb/tb_mmio_store_sink.sv
// Bench for mmio_store_sink: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_mmio_store_sink;

    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] SIZE   = 32'h40;
    localparam logic [31:0] TOHOST = 32'h64;
    localparam logic [31:0] PASSV  = 32'd25;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        outValid;
    logic        outReady;
    logic [31:0] outAddr;
    logic [31:0] outData;
    logic [2:0]  fifoLevel;
    logic        overflow;
    logic        misalign;
    logic        pass;
    logic        fail;
    logic [15:0] storeCount;

    int passCount  = 0;
    int totalCount = 0;

    mmio_store_sink dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .data        (data),
        .we          (we),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_addr    (outAddr),
        .out_data    (outData),
        .fifo_level  (fifoLevel),
        .overflow    (overflow),
        .misalign    (misalign),
        .pass        (pass),
        .fail        (fail),
        .store_count (storeCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          preReset;
        logic [31:0] vAddr;
        logic [31:0] vData;
        bit          vWe;
        bit          vReady;
        bit          expValid;
        logic [31:0] expAddr;
        logic [31:0] expData;
        int          expLevel;
        bit          expOvf;
        int          expCount;
    } vec_t;

    typedef struct {
        logic [31:0] offs;
        logic [31:0] val;
    } entry_t;

    // Reference model: an ordered queue of buffered stores plus plain status variables.
    entry_t modelQ[$];
    bit     modelOvf;
    bit     modelMis;
    int     modelStatus;
    int     modelCount;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r);
        addr     = a;
        data     = d;
        we       = w;
        outReady = r;
        @(posedge clk);
        #2;
        we       = 1'b0;
        outReady = 1'b0;
    endtask

    task automatic doReset();
        we       = 1'b0;
        outReady = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        modelQ.delete();
        modelOvf    = 0;
        modelMis    = 0;
        modelStatus = 0;
        modelCount  = 0;
    endtask

    task automatic modelStep(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r);
        longint ua;
        bit     popNow;
        bit     mis;
        ua     = longint'(a);
        popNow = (modelQ.size() > 0) && r;
`ifdef MMIO_ALIGN_CHECK_EN
        mis = (ua % 4) != 0;
`else
        mis = 0;
`endif
        if (popNow) void'(modelQ.pop_front());
        if (w && modelStatus == 0) begin
            if (modelCount < 65535) modelCount++;
            if (a == TOHOST) begin
                if (mis) modelMis = 1;
                else modelStatus = (d == PASSV) ? 1 : 2;
            end else if (ua >= longint'(BASE) && ua < longint'(BASE) + longint'(SIZE)) begin
                if (mis) modelMis = 1;
                else if (modelQ.size() >= DEPTH) modelOvf = 1;
                else modelQ.push_back('{a - BASE, d});
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("rnd_valid", 32'(outValid), 32'(modelQ.size() > 0));
        checkOutput("rnd_level", 32'(fifoLevel), 32'(modelQ.size()));
        checkOutput("rnd_overflow", 32'(overflow), 32'(modelOvf));
        checkOutput("rnd_misalign", 32'(misalign), 32'(modelMis));
        checkOutput("rnd_pass", 32'(pass), 32'(modelStatus == 1));
        checkOutput("rnd_fail", 32'(fail), 32'(modelStatus == 2));
        checkOutput("rnd_count", 32'(storeCount), 32'(modelCount));
        if (modelQ.size() > 0) begin
            checkOutput("rnd_head_addr", outAddr, modelQ[0].offs);
            checkOutput("rnd_head_data", outData, modelQ[0].val);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_addr"}, outAddr, 32'd0);
        checkOutput({tag, "_data"}, outData, 32'd0);
        checkOutput({tag, "_level"}, 32'(fifoLevel), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_misalign"}, 32'(misalign), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_fail"}, 32'(fail), 32'd0);
        checkOutput({tag, "_count"}, 32'(storeCount), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        bit          rw;
        bit          rr;
        int          sel;

        rst_n    = 1'b0;
        addr     = '0;
        data     = '0;
        we       = 1'b0;
        outReady = 1'b0;

        // Single store then drain; five stores into depth 4 with overflow; full push+pop.
        vecs.push_back('{0, 32'h104, 32'hA5, 1, 0, 1, 32'h4,  32'hA5, 1, 0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 0, 32'h0,  32'h0,  0, 0, 1});
        vecs.push_back('{0, 32'h100, 32'h10, 1, 0, 1, 32'h0,  32'h10, 1, 0, 2});
        vecs.push_back('{0, 32'h104, 32'h11, 1, 0, 1, 32'h0,  32'h10, 2, 0, 3});
        vecs.push_back('{0, 32'h108, 32'h12, 1, 0, 1, 32'h0,  32'h10, 3, 0, 4});
        vecs.push_back('{0, 32'h10C, 32'h13, 1, 0, 1, 32'h0,  32'h10, 4, 0, 5});
        vecs.push_back('{0, 32'h110, 32'h14, 1, 0, 1, 32'h0,  32'h10, 4, 1, 6});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'h4,  32'h11, 3, 1, 6});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'h8,  32'h12, 2, 1, 6});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'hC,  32'h13, 1, 1, 6});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 0, 32'h0,  32'h0,  0, 1, 6});
        vecs.push_back('{1, 32'h100, 32'h20, 1, 0, 1, 32'h0,  32'h20, 1, 0, 1});
        vecs.push_back('{0, 32'h104, 32'h21, 1, 0, 1, 32'h0,  32'h20, 2, 0, 2});
        vecs.push_back('{0, 32'h108, 32'h22, 1, 0, 1, 32'h0,  32'h20, 3, 0, 3});
        vecs.push_back('{0, 32'h10C, 32'h23, 1, 0, 1, 32'h0,  32'h20, 4, 0, 4});
        vecs.push_back('{0, 32'h120, 32'h30, 1, 1, 1, 32'h4,  32'h21, 4, 0, 5});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'h8,  32'h22, 3, 0, 5});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'hC,  32'h23, 2, 0, 5});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 1, 32'h20, 32'h30, 1, 0, 5});
        vecs.push_back('{0, 32'h0,   32'h0,  0, 1, 0, 32'h0,  32'h0,  0, 0, 5});

        #12;
        checkAllZero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].preReset) doReset();
            applyStimulus(vecs[i].vAddr, vecs[i].vData, vecs[i].vWe, vecs[i].vReady);
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_level", i), 32'(fifoLevel), 32'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d_count", i), 32'(storeCount), 32'(vecs[i].expCount));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_addr", i), outAddr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d_data", i), outData, vecs[i].expData);
            end
        end

        // Pass is terminal: later stores neither push, count nor flip to fail.
        doReset();
        applyStimulus(32'h64, 32'd25, 1, 0);
        checkOutput("pass_set", 32'(pass), 32'd1);
        checkOutput("pass_fail_low", 32'(fail), 32'd0);
        applyStimulus(32'h104, 32'h55, 1, 0);
        checkOutput("pass_nopush_level", 32'(fifoLevel), 32'd0);
        checkOutput("pass_nopush_count", 32'(storeCount), 32'd1);
        applyStimulus(32'h64, 32'd3, 1, 0);
        checkOutput("pass_still_pass", 32'(pass), 32'd1);
        checkOutput("pass_no_fail", 32'(fail), 32'd0);
        checkOutput("pass_count_frozen", 32'(storeCount), 32'd1);

        // Fail with two buffered entries, then asynchronous reset between edges.
        doReset();
        applyStimulus(32'h100, 32'h1, 1, 0);
        applyStimulus(32'h104, 32'h2, 1, 0);
        applyStimulus(32'h64, 32'd7, 1, 0);
        checkOutput("fail_set", 32'(fail), 32'd1);
        checkOutput("fail_pass_low", 32'(pass), 32'd0);
        checkOutput("fail_level", 32'(fifoLevel), 32'd2);
        checkOutput("fail_count", 32'(storeCount), 32'd3);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        #1;
        rst_n = 1'b1;

        // Misaligned in-window store.
        doReset();
        applyStimulus(32'h102, 32'h77, 1, 0);
        checkOutput("mis_count", 32'(storeCount), 32'd1);
`ifdef MMIO_ALIGN_CHECK_EN
        checkOutput("mis_flag", 32'(misalign), 32'd1);
        checkOutput("mis_level", 32'(fifoLevel), 32'd0);
        checkOutput("mis_valid", 32'(outValid), 32'd0);
`else
        checkOutput("mis_flag", 32'(misalign), 32'd0);
        checkOutput("mis_level", 32'(fifoLevel), 32'd1);
        checkOutput("mis_addr", outAddr, 32'h2);
        checkOutput("mis_data", outData, 32'h77);
`endif

        // Randomized traffic with occasional resets and rare tohost writes.
        doReset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) doReset();
            sel = int'($urandom_range(0, 9));
            rd  = $urandom;
            case (sel)
                0, 1, 2, 3, 4: ra = BASE + 32'($urandom_range(0, 63));
                5:             ra = ($urandom_range(0, 1) == 1) ? 32'hFF : 32'h140;
                6:             ra = 32'h13F;
                7:             ra = $urandom;
                8:             ra = 32'h13C;
                default: begin
                    if ($urandom_range(0, 9) == 0) begin
                        ra = TOHOST;
                        if ($urandom_range(0, 1) == 1) rd = PASSV;
                    end else begin
                        ra = BASE;
                    end
                end
            endcase
            rw = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 9) < 4);
            modelStep(ra, rd, rw, rr);
            applyStimulus(ra, rd, rw, rr);
            checkModel();
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/mmio_store_sink.md
Name: mmio_store_sink

Overview:
Responder for the core's store-side outputs `addr`, `data` and `we`. It decodes a memory-mapped window, buffers in-window stores in a FIFO and drains them on a valid/ready stream. It also implements a tohost pass/fail status register and a store counter. It sits beside the data memory at the top level, observing the same store interface, and feeds the simulation/console harness.

Parameters:
- MMIO_BASE, 32'h0000_0100: first byte address of the buffered window.
- MMIO_SIZE, 32'h0000_0040: window size in bytes; window is [MMIO_BASE, MMIO_BASE+MMIO_SIZE).
- TOHOST_ADDR, 32'h0000_0064: status address; excluded from the window decode even if inside it.
- PASS_VALUE, 32'd25: data value at TOHOST_ADDR that signals pass.
- FIFO_DEPTH, 4: buffer entries; power of two, minimum 2.
- CNT_W, 16: store counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  32  store address from core memory stage.
- data  in  32  store data from core memory stage.
- we  in  1  store strobe; one store per cycle while high.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_addr  out  32  head address, offset from MMIO_BASE.
- out_data  out  32  head data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; an in-window store was dropped.
- misalign  out  1  sticky; see Optional Feature.
- pass  out  1  status FSM in PASS.
- fail  out  1  status FSM in FAIL.
- store_count  out  CNT_W  number of accepted stores, saturating.

Behaviour:
- Reset, asynchronous: FIFO empty, out_valid=0, out_addr=0, out_data=0, fifo_level=0, overflow=0, misalign=0, pass=0, fail=0, store_count=0, FSM=RUN.
- Reset mid-operation discards all buffered entries and clears every status bit immediately, with no clock required.
- Decode: hit = we & (addr >= MMIO_BASE) & (addr - MMIO_BASE < MMIO_SIZE) & (addr != TOHOST_ADDR). Compare in 33 bits so MMIO_BASE+MMIO_SIZE cannot wrap.
- Push: a hit at edge N is written at edge N and is visible on out_valid/out_* after edge N (latency 1).
  - FIFO is registered.
  - out_* come from the head register, not combinationally from inputs.
- Pop: out_valid & out_ready at edge N removes the head. The next entry appears after edge N.
- Full rules:
  - Push while full with no pop: store dropped, overflow set, level unchanged.
  - Push and pop in the same cycle while full: both succeed, level stays FIFO_DEPTH, no overflow.
- Empty rules:
  - out_valid=0 and out_ready is ignored.
  - Push and pop cannot coincide when empty; a push into an empty FIFO makes out_valid=1 next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fifo_level = write count - read count, range 0..FIFO_DEPTH.
- Status FSM, states RUN, PASS, FAIL:
  - RUN -> PASS on we & addr==TOHOST_ADDR & data==PASS_VALUE.
  - RUN -> FAIL on we & addr==TOHOST_ADDR & data!=PASS_VALUE.
  - PASS and FAIL are terminal until reset.
  - In PASS/FAIL all further stores are ignored: no push, no count, no sticky updates. Draining continues.
- store_count: +1 on every we cycle in RUN, including out-of-window and tohost stores. Saturates at 2^CNT_W-1.
- Stores outside the window (and not tohost) only increment store_count.
- we high with X on addr in RUN is a bench error; no defined behaviour.

Optional Feature:
Macro MMIO_ALIGN_CHECK_EN.
- Defined: a hit with addr[1:0]!=0 is not pushed and sets misalign. Tohost stores with addr[1:0]!=0 do not change FSM state; they are counted and set misalign.
- Undefined: no alignment check; misalign tied to 0; misaligned addresses are pushed unchanged.

Test Plan:
1. Reset then store addr=0x104 data=0xA5 with out_ready=0 -> next cycle out_valid=1, out_addr=0x4, out_data=0xA5, fifo_level=1, store_count=1.
2. Five back-to-back in-window stores (0x100..0x110) with out_ready=0, depth 4 -> fifo_level=4, overflow=1, head data from the 0x100 store. Then out_ready=1 for 4 cycles -> entries drained in order, out_valid=0.
3. FIFO full, out_ready=1 and a store to 0x120 in the same cycle -> fifo_level stays 4, overflow stays 0, last entry data matches the 0x120 store.
4. Store addr=0x64 data=25 -> pass=1 next cycle. A following store to 0x104 -> not pushed, store_count unchanged. A later store to 0x64 data=3 -> fail remains 0.
5. Store addr=0x64 data=7 -> fail=1, pass=0. Assert rst_n low mid-cycle with 2 entries buffered -> all outputs 0 immediately.
6. MMIO_ALIGN_CHECK_EN defined, store addr=0x102 -> misalign=1, fifo_level=0, store_count=1. Undefined: entry pushed with out_addr=0x2, misalign=0.
